// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  localparam int WORD = 32;
  localparam logic [WORD-1:0] NOP_INSTR_DEF = 32'h00000020;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DISCARD} fetchState_t;

  typedef struct packed {
    logic [WORD-1:0] instr;
    logic [WORD-1:0] pc;
  } fetchEntry_t;
endpackage

// File: rtl/fetch_if.sv
// Request/acknowledge read bus between the fetch stage and instruction SRAM.
interface fetch_if;
  import fetch_pkg::*;
  logic            imem_req;
  logic [WORD-1:0] imem_addr;
  logic            imem_ack;
  logic [WORD-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_skid.sv
// One-entry instruction/PC holding register used when ID stalls on a returning fetch.
module fetch_skid import fetch_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  fetchEntry_t dIn,
  output logic        valid,
  output fetchEntry_t q
);
  // clear wins so a flush can never leave a stale entry behind
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= dIn;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issues SRAM reads from NextPC and fills the IF/ID register,
// absorbing ID stalls with a one-entry skid and dropping data on taken branches.
module fetch_stage import fetch_pkg::*; #(
  parameter logic [WORD-1:0] RESET_PC  = '0,
  parameter logic [WORD-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [WORD-1:0] pc,
  input  logic            branch,
  input  logic            id_stall,
  fetch_if.master         mem,
  output logic            fetch_stall,
  output logic            if_valid,
  output logic [WORD-1:0] if_instr,
  output logic [WORD-1:0] if_pc,
  output logic [WORD-1:0] if_pc4
);
  fetchState_t state;
  logic        accept;
  logic        skidLoad, skidClear, skidValid;
  fetchEntry_t skidIn, skidQ;

  assign accept      = !id_stall || !if_valid;
  assign fetch_stall = !(state == WAIT && mem.imem_ack && accept && !branch);
  assign if_pc4      = if_pc + 32'd4;

  assign skidIn    = '{instr: mem.imem_rdata, pc: mem.imem_addr};
  assign skidLoad  = (state == WAIT) && mem.imem_ack && !branch && !accept;
  assign skidClear = (state == HOLD) && (branch || accept);

  fetch_skid uSkid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skidLoad),
    .clear (skidClear),
    .dIn   (skidIn),
    .valid (skidValid),
    .q     (skidQ)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      mem.imem_req  <= 1'b0;
      mem.imem_addr <= RESET_PC;
      if_valid      <= 1'b0;
      if_instr      <= NOP_INSTR;
      if_pc         <= '0;
    end else begin
      // Bubble/flush by default; the state-specific loads below override it.
      if (branch || accept) begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end
      case (state)
        IDLE: begin
          mem.imem_addr <= pc;
          mem.imem_req  <= 1'b1;
          state         <= WAIT;
        end
        WAIT: begin
          if (mem.imem_ack) begin
            mem.imem_req <= 1'b0;
            if (branch) begin
              state <= IDLE;
            end else if (accept) begin
              if_valid <= 1'b1;
              if_instr <= mem.imem_rdata;
              if_pc    <= mem.imem_addr;
              state    <= IDLE;
            end else begin
              state <= HOLD;
            end
          end else if (branch) begin
            state <= DISCARD;
          end
        end
        HOLD: begin
          if (branch) begin
            state <= IDLE;
          end else if (accept) begin
            if (skidValid) begin
              if_valid <= 1'b1;
              if_instr <= skidQ.instr;
              if_pc    <= skidQ.pc;
            end
            state <= IDLE;
          end
        end
        DISCARD: begin
          // The in-flight read still has to complete before a new one can go out.
          if (mem.imem_ack) begin
            mem.imem_req <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage: stimulus pushes expected IF/ID entries,
// a monitor pops them when ID consumes a live instruction.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        branch, id_stall;
  logic        fetch_stall, if_valid;
  logic [31:0] if_instr, if_pc, if_pc4;
  int          nChecks = 0;
  int          nErr = 0;
  fetchEntry_t sbQ[$];

  fetch_if mem ();

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h20)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .branch      (branch),
    .id_stall    (id_stall),
    .mem         (mem),
    .fetch_stall (fetch_stall),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc4      (if_pc4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [31:0] instr, input logic [31:0] addr);
    fetchEntry_t e;
    e.instr = instr;
    e.pc    = addr;
    sbQ.push_back(e);
  endtask

  task automatic checkReset(input string tag);
    chk({tag, "_req"},   {31'd0, mem.imem_req}, 32'd0);
    chk({tag, "_addr"},  mem.imem_addr, 32'h0);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
    chk({tag, "_instr"}, if_instr, 32'h20);
    chk({tag, "_pc"},    if_pc, 32'h0);
    chk({tag, "_pc4"},   if_pc4, 32'h4);
    chk({tag, "_stall"}, {31'd0, fetch_stall}, 32'd1);
  endtask

  // Monitor: ID consumes the IF/ID entry in any cycle it is live and not stalled/flushed.
  always @(negedge clk) begin
    if (rst_n && if_valid && !id_stall && !branch) begin
      if (sbQ.size() == 0) begin
        chk("sb_underflow_instr", if_instr, 32'hxxxxxxxx);
      end else begin
        fetchEntry_t e;
        e = sbQ.pop_front();
        chk("sb_instr", if_instr, e.instr);
        chk("sb_pc",    if_pc, e.pc);
        chk("sb_pc4",   if_pc4, e.pc + 32'd4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; pc = '0; branch = 1'b0; id_stall = 1'b0;
    mem.imem_ack = 1'b0; mem.imem_rdata = '0;
    repeat (3) tick();
    checkReset("rst");

    // zero-wait fetch from pc 0
    rst_n = 1'b1;
    tick();
    chk("t1_req", {31'd0, mem.imem_req}, 32'd1);
    chk("t1_addr", mem.imem_addr, 32'h0);
    chk("t1_stall_wait", {31'd0, fetch_stall}, 32'd1);
    mem.imem_ack = 1'b1; mem.imem_rdata = 32'h20010005; pushExp(32'h20010005, 32'h0);
    #1 chk("t1_stall_ack", {31'd0, fetch_stall}, 32'd0);
    pc = 32'h1000;
    tick(); mem.imem_ack = 1'b0; #1;
    chk("t1_valid", {31'd0, if_valid}, 32'd1);
    chk("t1_pc4", if_pc4, 32'h4);
    chk("t1_req_drop", {31'd0, mem.imem_req}, 32'd0);
    chk("t1_stall_after", {31'd0, fetch_stall}, 32'd1);

    // three-cycle memory latency
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("t2_req", {31'd0, mem.imem_req}, 32'd1);
      chk("t2_addr", mem.imem_addr, 32'h1000);
      chk("t2_stall", {31'd0, fetch_stall}, 32'd1);
      tick();
    end
    chk("t2_req3", {31'd0, mem.imem_req}, 32'd1);
    chk("t2_addr3", mem.imem_addr, 32'h1000);
    mem.imem_ack = 1'b1; mem.imem_rdata = 32'h13572468; pushExp(32'h13572468, 32'h1000);
    #1 chk("t2_stall_ack", {31'd0, fetch_stall}, 32'd0);
    pc = 32'h2000;
    tick(); mem.imem_ack = 1'b0; #1;
    chk("t2_valid", {31'd0, if_valid}, 32'd1);
    chk("t2_pc", if_pc, 32'h1000);
    id_stall = 1'b1;

    // ack while ID stalls goes to the skid
    tick();
    chk("t3_addr", mem.imem_addr, 32'h2000);
    chk("t3_hold_instr", if_instr, 32'h13572468);
    mem.imem_ack = 1'b1; mem.imem_rdata = 32'hAAAA0000; pushExp(32'hAAAA0000, 32'h2000);
    #1 chk("t3_stall_noaccept", {31'd0, fetch_stall}, 32'd1);
    tick(); mem.imem_ack = 1'b0; #1;
    chk("t3_req", {31'd0, mem.imem_req}, 32'd0);
    chk("t3_stall_hold", {31'd0, fetch_stall}, 32'd1);
    chk("t3_ifid_kept", if_instr, 32'h13572468);
    tick();
    chk("t3_ifid_kept2", if_instr, 32'h13572468);
    chk("t3_req2", {31'd0, mem.imem_req}, 32'd0);
    id_stall = 1'b0;
    tick();
    chk("t3_skid_instr", if_instr, 32'hAAAA0000);
    chk("t3_skid_pc", if_pc, 32'h2000);
    chk("t3_skid_valid", {31'd0, if_valid}, 32'd1);
    pc = 32'h3000;

    // branch in WAIT without ack, late ack discarded
    tick();
    chk("t4_addr", mem.imem_addr, 32'h3000);
    chk("t4_bubble", {31'd0, if_valid}, 32'd0);
    branch = 1'b1; pc = 32'h4000;
    tick(); branch = 1'b0; #1;
    chk("t4_req_disc", {31'd0, mem.imem_req}, 32'd1);
    chk("t4_flush_instr", if_instr, 32'h20);
    tick();
    chk("t4_req_disc2", {31'd0, mem.imem_req}, 32'd1);
    mem.imem_ack = 1'b1; mem.imem_rdata = 32'hDEADBEEF;
    #1 chk("t4_stall_disc_ack", {31'd0, fetch_stall}, 32'd1);
    tick(); mem.imem_ack = 1'b0; #1;
    chk("t4_req_drop", {31'd0, mem.imem_req}, 32'd0);
    chk("t4_valid", {31'd0, if_valid}, 32'd0);
    chk("t4_instr", if_instr, 32'h20);
    tick();
    chk("t4_target", mem.imem_addr, 32'h4000);
    mem.imem_ack = 1'b1; mem.imem_rdata = 32'h11112222;
    #1 chk("t4_stall_ack", {31'd0, fetch_stall}, 32'd0);
    pc = 32'h5000;
    tick(); mem.imem_ack = 1'b0; #1;
    chk("t4_load", if_instr, 32'h11112222);
    chk("t4_load_pc", if_pc, 32'h4000);
    id_stall = 1'b1;

    // branch in HOLD empties the skid
    tick();
    chk("t5_addr", mem.imem_addr, 32'h5000);
    mem.imem_ack = 1'b1; mem.imem_rdata = 32'hBBBB0000;
    tick(); mem.imem_ack = 1'b0; #1;
    chk("t5_req", {31'd0, mem.imem_req}, 32'd0);
    chk("t5_hold_instr", if_instr, 32'h11112222);
    branch = 1'b1; pc = 32'h6000;
    tick(); branch = 1'b0; id_stall = 1'b0; #1;
    chk("t5_valid", {31'd0, if_valid}, 32'd0);
    chk("t5_instr", if_instr, 32'h20);
    tick();
    chk("t5_target", mem.imem_addr, 32'h6000);
    chk("t5_req2", {31'd0, mem.imem_req}, 32'd1);
    mem.imem_ack = 1'b1; mem.imem_rdata = 32'h66660001; pushExp(32'h66660001, 32'h6000);
    #1 chk("t5_stall_ack", {31'd0, fetch_stall}, 32'd0);
    pc = 32'h7000;
    tick(); mem.imem_ack = 1'b0; #1;
    chk("t5_load", if_instr, 32'h66660001);

    // reset mid-request, late ack ignored
    tick();
    chk("t6_req", {31'd0, mem.imem_req}, 32'd1);
    chk("t6_addr", mem.imem_addr, 32'h7000);
    rst_n = 1'b0;
    tick();
    mem.imem_ack = 1'b1; mem.imem_rdata = 32'h99999999;
    #1 checkReset("t6_rst");
    tick();
    rst_n = 1'b1;
    tick(); mem.imem_ack = 1'b0; #1;
    chk("t6_valid", {31'd0, if_valid}, 32'd0);
    chk("t6_instr", if_instr, 32'h20);
    chk("t6_req", {31'd0, mem.imem_req}, 32'd1);
    chk("t6_addr2", mem.imem_addr, 32'h7000);
    mem.imem_ack = 1'b1; mem.imem_rdata = 32'h77770000; pushExp(32'h77770000, 32'h7000);
    #1 chk("t6_stall_ack", {31'd0, fetch_stall}, 32'd0);
    tick(); mem.imem_ack = 1'b0; #1;
    chk("t6_load", if_instr, 32'h77770000);
    tick(); tick();
    chk("sb_empty", sbQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage directly downstream of the PC register. It samples the PC's NextPC, issues a request/acknowledge read to instruction SRAM, and loads the IF/ID pipeline register with instruction, PC and valid bit. It tolerates variable memory latency and ID-stage stalls through a one-entry skid register. Its fetch_stall output drives the PC's stall input, and imem_addr feeds the PC's CurrPC input.

Parameters:
RESET_PC, 32'h00000000, imem_addr value at reset.
NOP_INSTR, 32'h00000020, instruction presented when the IF/ID register is invalid or flushed.

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  reset; synchronous, active-low.
pc  in  32  NextPC from the PC stage; sampled at posedge.
branch  in  1  taken branch resolved downstream; flush.
id_stall  in  1  ID cannot accept a new instruction this cycle.
imem_req  out  1  read request to instruction SRAM.
imem_addr  out  32  word address of the request; also drives PC CurrPC.
imem_ack  in  1  read data valid this cycle.
imem_rdata  in  32  instruction word, valid when imem_ack=1.
fetch_stall  out  1  PC must hold (combinational).
if_valid  out  1  IF/ID register holds a live instruction.
if_instr  out  32  IF/ID instruction.
if_pc  out  32  IF/ID address of if_instr.
if_pc4  out  32  if_pc+4 (combinational, modulo 2^32).

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=NOP_INSTR, if_pc=0, skid empty. rst_n overrides everything, including mid-request; a late imem_ack after reset is ignored because the state is IDLE.
- accept = !id_stall | !if_valid.
- States:
  - IDLE: next posedge sets imem_addr<=pc, imem_req<=1, goes to WAIT. If branch=1 in the same cycle, the IF/ID flush still applies and the request is still issued, using the branch-updated pc.
  - WAIT: imem_req and imem_addr stay stable until imem_ack.
    - On ack with branch=1: data is dropped, go to IDLE.
    - On ack with accept=1: IF/ID loads {rdata, imem_addr, valid=1}, go to IDLE.
    - On ack with accept=0: skid loads {rdata, imem_addr}, go to HOLD.
    - No ack with branch=1: go to DISCARD.
    - imem_req drops the cycle after ack.
  - HOLD: skid occupied; imem_req=0. When accept=1, IF/ID loads the skid and the state goes to IDLE. branch=1 empties the skid and goes to IDLE.
  - DISCARD: request still outstanding; imem_req stays high until imem_ack. On ack, data is dropped and the state goes to IDLE. branch is ignored here (flush already pending).
- fetch_stall = !(state==WAIT & imem_ack & accept & !branch). The PC advances exactly once per accepted instruction; branch priority inside the PC handles redirect.
- IF/ID register rules:
  - branch=1 has priority over everything: if_valid<=0, if_instr<=NOP_INSTR.
  - Otherwise, when id_stall=1 and if_valid=1, contents hold.
  - Otherwise, when accept=1 and nothing is loaded, if_valid<=0 and if_instr<=NOP_INSTR (bubble).
- Minimum throughput: one instruction per 2 cycles at zero-wait memory (IDLE→WAIT→ack).
- Memory latency: arbitrary. No timeout is required.

Decomposition:
- Package fetch_pkg: state enum {IDLE, WAIT, HOLD, DISCARD}, NOP_INSTR default, WORD=32.
- One natural sub-module, fetch_skid: a 1-entry instruction/PC holding register with load/clear/valid.

Test Plan:
- Reset, then rst_n=1, pc=0, memory acks 1 cycle after req with 0x20010005 → imem_addr=0, if_valid=1, if_instr=0x20010005, if_pc=0, if_pc4=4; fetch_stall low for exactly the ack cycle.
- Memory latency 3 cycles, pc=0x1000 → imem_req high 3 cycles, fetch_stall=1 throughout, imem_addr=0x1000 stable; IF/ID loads on ack.
- id_stall=1 with if_valid=1 while ack returns 0xAAAA0000 → skid captures it, state HOLD, IF/ID unchanged, fetch_stall=1; drop id_stall → IF/ID=0xAAAA0000 next cycle.
- branch=1 in WAIT with no ack; ack arrives 2 cycles later → if_valid=0, if_instr=0x00000020, returned data never appears; next request uses the branch target from pc.
- branch=1 in HOLD → skid discarded, if_valid=0, next request issued from pc.
- rst_n=0 while in WAIT, then a late imem_ack → all outputs at reset values, no IF/ID load.
